// File: rtl/mfp_ahb_lite_req_master.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module  : mfp_ahb_lite_req_master
// Brief   : Single-outstanding request/response to AHB-Lite master bridge.
// Revision: 1.0 - initial release
// ============================================================================
module mfp_ahb_lite_req_master #(
    parameter int MAX_WAIT = 16
) (
    input  logic        HCLK,
    input  logic        HRESET,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [31:0] req_addr,
    input  logic [2:0]  req_size,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err,
    output logic        timeout,
    output logic [31:0] HADDR,
    output logic [2:0]  HSIZE,
    output logic        HWRITE,
    output logic [1:0]  HTRANS,
    output logic [2:0]  HBURST,
    output logic        HMASTLOCK,
    output logic [3:0]  HPROT,
    output logic [31:0] HWDATA,
    input  logic [31:0] HRDATA,
    input  logic        HREADY,
    input  logic        HRESP
);

    localparam int             WAIT_W       = $clog2(MAX_WAIT + 1);
    localparam logic [WAIT_W-1:0] C_WAIT_MAX = WAIT_W'(MAX_WAIT);
    localparam logic [1:0]     C_HTRANS_IDLE   = 2'b00;
    localparam logic [1:0]     C_HTRANS_NONSEQ = 2'b10;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ADDR = 2'd1,
        S_DATA = 2'd2,
        S_ERR  = 2'd3
    } state_t;

    state_t             state_q, state_d;
    logic [31:0]        addr_q, addr_d;
    logic [2:0]         size_q, size_d;
    logic               write_q, write_d;
    logic [31:0]        wdata_q, wdata_d;
    logic               rsp_valid_q, rsp_valid_d;
    logic               rsp_err_q, rsp_err_d;
    logic [31:0]        rsp_rdata_q, rsp_rdata_d;
    logic               timeout_q, timeout_d;
    logic [WAIT_W-1:0]  wait_q, wait_d;
    logic               misaligned;

    // Illegal size or misaligned address short-circuits to a local error.
    always_comb begin
        misaligned = 1'b0;
        if (req_size > 3'd2)
            misaligned = 1'b1;
        else if (req_size == 3'd1 && req_addr[0])
            misaligned = 1'b1;
        else if (req_size == 3'd2 && req_addr[1:0] != 2'b00)
            misaligned = 1'b1;
    end

    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        size_d      = size_q;
        write_d     = write_q;
        wdata_d     = wdata_q;
        rsp_valid_d = 1'b0;
        rsp_err_d   = rsp_err_q;
        rsp_rdata_d = rsp_rdata_q;
        timeout_d   = timeout_q;
        wait_d      = wait_q;
        case (state_q)
            S_IDLE: begin
                if (req_valid) begin
                    addr_d  = req_addr;
                    size_d  = req_size;
                    write_d = req_write;
                    wdata_d = req_wdata;
                    state_d = misaligned ? S_ERR : S_ADDR;
                end
            end
            S_ADDR: begin
                if (HREADY) begin
                    state_d = S_DATA;
                    wait_d  = '0;
                end
            end
            S_DATA: begin
                if (HREADY) begin
                    rsp_valid_d = 1'b1;
                    rsp_err_d   = HRESP;
                    if (!write_q)
                        rsp_rdata_d = HRDATA;
                    state_d = S_IDLE;
                end else if (wait_q != C_WAIT_MAX) begin
                    // Timeout is only a flag; the transfer keeps waiting.
                    wait_d = wait_q + 1'b1;
                    if ((wait_q + 1'b1) == C_WAIT_MAX)
                        timeout_d = 1'b1;
                end
            end
            S_ERR: begin
                rsp_valid_d = 1'b1;
                rsp_err_d   = 1'b1;
                state_d     = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            state_q     <= S_IDLE;
            addr_q      <= '0;
            size_q      <= '0;
            write_q     <= 1'b0;
            wdata_q     <= '0;
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= 1'b0;
            rsp_rdata_q <= '0;
            timeout_q   <= 1'b0;
            wait_q      <= '0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            size_q      <= size_d;
            write_q     <= write_d;
            wdata_q     <= wdata_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_err_q   <= rsp_err_d;
            rsp_rdata_q <= rsp_rdata_d;
            timeout_q   <= timeout_d;
            wait_q      <= wait_d;
        end
    end

    assign req_ready = (state_q == S_IDLE) && !HRESET;
    assign HTRANS    = (state_q == S_ADDR) ? C_HTRANS_NONSEQ : C_HTRANS_IDLE;
    assign HADDR     = addr_q;
    assign HSIZE     = size_q;
    assign HWRITE    = write_q;
    assign HWDATA    = wdata_q;
    assign HBURST    = 3'b000;
    assign HMASTLOCK = 1'b0;
    assign HPROT     = 4'b0011;
    assign rsp_valid = rsp_valid_q;
    assign rsp_err   = rsp_err_q;
    assign rsp_rdata = rsp_rdata_q;
    assign timeout   = timeout_q;

endmodule
`default_nettype wire

// File: tb/tb_mfp_ahb_lite_req_master.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module  : tb_mfp_ahb_lite_req_master
// Brief   : Directed bench with a response scoreboard for the AHB-Lite master.
// Revision: 1.0 - initial release
// ============================================================================
module tb_mfp_ahb_lite_req_master;

    localparam int MAX_WAIT = 4;

    logic        HCLK = 1'b0;
    logic        HRESET;
    logic        req_valid, req_ready, req_write;
    logic [31:0] req_addr, req_wdata;
    logic [2:0]  req_size;
    logic        rsp_valid, rsp_err, timeout;
    logic [31:0] rsp_rdata;
    logic [31:0] HADDR, HWDATA, HRDATA;
    logic [2:0]  HSIZE, HBURST;
    logic        HWRITE, HMASTLOCK, HREADY, HRESP;
    logic [1:0]  HTRANS;
    logic [3:0]  HPROT;

    mfp_ahb_lite_req_master #(.MAX_WAIT(MAX_WAIT)) dut (
        .HCLK(HCLK), .HRESET(HRESET),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_addr(req_addr), .req_size(req_size), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
        .timeout(timeout),
        .HADDR(HADDR), .HSIZE(HSIZE), .HWRITE(HWRITE), .HTRANS(HTRANS),
        .HBURST(HBURST), .HMASTLOCK(HMASTLOCK), .HPROT(HPROT),
        .HWDATA(HWDATA), .HRDATA(HRDATA), .HREADY(HREADY), .HRESP(HRESP)
    );

    always #5 HCLK = ~HCLK;

    typedef struct {
        logic        err;
        logic [31:0] rdata;
        int          cyc;
    } exp_t;

    exp_t        sb_q[$];
    int          tests = 0;
    int          fails = 0;
    int          cyc   = 0;
    logic [31:0] rdata_model;
    logic        tout_model;

    always @(posedge HCLK) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Response monitor: every rsp_valid pulse must match the oldest expectation.
    always @(negedge HCLK) begin
        if (rsp_valid === 1'b1) begin
            if (sb_q.size() == 0) begin
                chk("unexpected_rsp", 32'd1, 32'd0);
            end else begin
                exp_t e;
                e = sb_q.pop_front();
                chk("rsp_err", {31'd0, rsp_err}, {31'd0, e.err});
                chk("rsp_rdata", rsp_rdata, e.rdata);
                chk("rsp_cycle", cyc, e.cyc);
            end
        end
    end

    task automatic do_req(input logic wr, input logic [31:0] addr, input logic [2:0] size,
                          input logic [31:0] wdata, input int aw, input int dw,
                          input logic [31:0] rd, input logic resp);
        logic illegal;
        exp_t e;
        illegal = (size > 3'd2) || (size == 3'd1 && addr[0]) ||
                  (size == 3'd2 && addr[1:0] != 2'b00);
        @(negedge HCLK);
        chk("req_ready_idle", {31'd0, req_ready}, 32'd1);
        chk("htrans_idle", {30'd0, HTRANS}, 32'd0);
        req_valid = 1'b1; req_write = wr; req_addr = addr;
        req_size = size; req_wdata = wdata;
        @(posedge HCLK); #1;
        e.err = illegal ? 1'b1 : resp;
        if (!illegal && !wr)
            rdata_model = rd;
        e.rdata = rdata_model;
        e.cyc   = illegal ? cyc + 1 : cyc + 2 + aw + dw;
        sb_q.push_back(e);
        // Requester keeps a garbage request pending while the block is busy.
        req_addr = 32'hFFFF_FFFF; req_size = 3'd7; req_write = ~wr; req_wdata = ~wdata;
        if (illegal) begin
            req_valid = 1'b0;
            @(negedge HCLK);
            chk("err_htrans", {30'd0, HTRANS}, 32'd0);
            chk("err_req_ready", {31'd0, req_ready}, 32'd0);
            @(posedge HCLK); #1;
            return;
        end
        for (int i = 0; i <= aw; i++) begin
            HREADY = (i == aw);
            @(negedge HCLK);
            chk("addr_htrans", {30'd0, HTRANS}, 32'd2);
            chk("addr_haddr", HADDR, addr);
            chk("addr_hsize", {29'd0, HSIZE}, {29'd0, size});
            chk("addr_hwrite", {31'd0, HWRITE}, {31'd0, wr});
            chk("addr_req_ready", {31'd0, req_ready}, 32'd0);
            @(posedge HCLK); #1;
        end
        HRDATA = rd;
        for (int i = 0; i <= dw; i++) begin
            if (i == dw) begin
                HREADY = 1'b1; HRESP = resp; req_valid = 1'b0;
            end else begin
                HREADY = 1'b0; HRESP = 1'b0;
            end
            @(negedge HCLK);
            chk("data_htrans", {30'd0, HTRANS}, 32'd0);
            chk("data_hwdata", HWDATA, wdata);
            chk("data_timeout", {31'd0, timeout}, {31'd0, tout_model || (i >= MAX_WAIT)});
            @(posedge HCLK); #1;
        end
        if (dw >= MAX_WAIT)
            tout_model = 1'b1;
        HREADY = 1'b1; HRESP = 1'b0; HRDATA = $urandom;
    endtask

    initial begin
        HRESET = 1'b1; req_valid = 1'b0; req_write = 1'b0; req_addr = '0;
        req_size = '0; req_wdata = '0; HRDATA = '0; HREADY = 1'b1; HRESP = 1'b0;
        rdata_model = '0; tout_model = 1'b0;
        repeat (3) @(posedge HCLK);
        @(negedge HCLK);
        chk("rst_req_ready", {31'd0, req_ready}, 32'd0);
        chk("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        chk("rst_rsp_err", {31'd0, rsp_err}, 32'd0);
        chk("rst_rsp_rdata", rsp_rdata, 32'd0);
        chk("rst_timeout", {31'd0, timeout}, 32'd0);
        chk("rst_htrans", {30'd0, HTRANS}, 32'd0);
        chk("rst_haddr", HADDR, 32'd0);
        chk("rst_hsize", {29'd0, HSIZE}, 32'd0);
        chk("rst_hwrite", {31'd0, HWRITE}, 32'd0);
        chk("rst_hwdata", HWDATA, 32'd0);
        chk("const_hburst", {29'd0, HBURST}, 32'd0);
        chk("const_hmastlock", {31'd0, HMASTLOCK}, 32'd0);
        chk("const_hprot", {28'd0, HPROT}, 32'h3);
        @(posedge HCLK); #1;
        HRESET = 1'b0;

        //     wr    addr          size  wdata          aw dw rdata          resp
        do_req(1'b1, 32'h0000_0010, 3'd2, 32'hDEAD_BEEF, 0, 0, 32'h1111_1111, 1'b0);
        do_req(1'b0, 32'h0000_0010, 3'd2, 32'h0000_0000, 0, 1, 32'hDEAD_BEEF, 1'b0);
        do_req(1'b1, 32'h0000_0003, 3'd1, 32'h1234_0000, 0, 0, 32'h0,         1'b0);
        do_req(1'b0, 32'h0000_0020, 3'd5, 32'h0,         0, 0, 32'h0,         1'b0);
        do_req(1'b0, 32'h0000_0002, 3'd2, 32'h0,         0, 0, 32'h0,         1'b0);
        do_req(1'b0, 32'h0000_0040, 3'd2, 32'h0,         0, 0, 32'h1234_5678, 1'b1);
        do_req(1'b1, 32'h0000_0007, 3'd0, 32'hAB00_0000, 2, 0, 32'h0,         1'b0);
        do_req(1'b0, 32'h0000_0006, 3'd1, 32'h0,         1, 2, 32'hCAFE_0000, 1'b0);
        do_req(1'b0, 32'h0000_0100, 3'd2, 32'h0,         0, 6, 32'h55AA_55AA, 1'b0);
        do_req(1'b1, 32'h0000_0104, 3'd2, 32'h0BAD_F00D, 0, 0, 32'h0,         1'b0);

        // Reset while the data phase is stalled.
        @(negedge HCLK);
        chk("pre_rst_timeout", {31'd0, timeout}, 32'd1);
        req_valid = 1'b1; req_write = 1'b0; req_addr = 32'h200; req_size = 3'd2;
        @(posedge HCLK); #1;
        req_valid = 1'b0; HREADY = 1'b1;
        @(posedge HCLK); #1;
        HREADY = 1'b0;
        @(negedge HCLK);
        chk("mid_data_htrans", {30'd0, HTRANS}, 32'd0);
        HRESET = 1'b1;
        @(posedge HCLK); #1;
        @(negedge HCLK);
        chk("mid_rst_htrans", {30'd0, HTRANS}, 32'd0);
        chk("mid_rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        chk("mid_rst_timeout", {31'd0, timeout}, 32'd0);
        chk("mid_rst_req_ready", {31'd0, req_ready}, 32'd0);
        @(posedge HCLK); #1;
        HRESET = 1'b0; HREADY = 1'b1;
        @(negedge HCLK);
        chk("post_rst_req_ready", {31'd0, req_ready}, 32'd1);
        repeat (3) @(posedge HCLK);
        @(negedge HCLK);
        chk("sb_drained", sb_q.size(), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
